// File: rtl/iomem_sevenseg_ctrl_pkg.sv
// Purpose: shared register map, CTRL field layout and blanking constants for the seven-segment slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iomem_sevenseg_pkg;

    // Register offsets, selected by iomem_addr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    // CTRL layout: [7:0] digit enable mask, [15:8] decimal-point mask
    localparam int CTRL_EN_LSB = 0;
    localparam int CTRL_DP_LSB = 8;
    localparam int CTRL_W      = 16;

    // Active-low "everything dark" values
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [7:0] ANODES_OFF = 8'hFF;

    // Enable every digit, no decimal points
    localparam logic [CTRL_W-1:0] CTRL_RESET = 16'h00FF;

endpackage

// File: rtl/iomem_sevenseg_ctrl_hex7seg_decode.sv
// Purpose: 4-bit hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
// Latency: combinational.
// Backpressure: none.
module hex7seg_decode (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Lookup of the active-low glyph for each hex digit
    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/iomem_sevenseg_ctrl.sv
// Purpose: iomem slave holding 8 hex digits + masks, time-multiplexed onto active-low segment/anode lines.
// Latency: iomem_ready one cycle after accept; display outputs lag register state by one cycle.
// Backpressure: none; the !iomem_ready term forces one idle cycle between accepted requests.
module iomem_sevenseg_ctrl
    import iomem_sevenseg_pkg::*;
#(
    parameter logic [7:0] ADDR_BASE   = 8'h04,
    parameter int         REFRESH_DIV = 100000,
    parameter int         DIV_W       = 17
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  anodes
);

    logic [31:0]       data_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DIV_W-1:0]  presc_q;
    logic [2:0]        idx_q;
    logic              blank_q;

    logic              accept;
    logic [1:0]        reg_sel;
    logic [31:0]       rd_val;
    logic              presc_last;
    logic [7:0]        en_mask;
    logic [7:0]        dp_mask;
    logic [3:0]        cur_nibble;
    logic [6:0]        cur_glyph;
    logic              digit_on;
    logic              unused_addr_bits;

    assign accept     = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_BASE);
    assign reg_sel    = iomem_addr[3:2];
    assign presc_last = (presc_q == DIV_W'(REFRESH_DIV - 1));
    assign en_mask    = ctrl_q[CTRL_EN_LSB +: 8];
    assign dp_mask    = ctrl_q[CTRL_DP_LSB +: 8];
    assign cur_nibble = data_q[{idx_q, 2'b00} +: 4];
    assign digit_on   = en_mask[idx_q] && !blank_q;

    // Only the tag byte and the word offset take part in decoding
    assign unused_addr_bits = ^{iomem_addr[23:4], iomem_addr[1:0]};

    hex7seg_decode u_decode (
        .nibble (cur_nibble),
        .seg    (cur_glyph)
    );

    // Read mux: returns the register value as it stands before this access's write
    always_comb begin
        rd_val = 32'd0;
        case (reg_sel)
            REG_DATA:   rd_val = data_q;
            REG_CTRL:   rd_val = {16'd0, ctrl_q};
            REG_STATUS: rd_val = {29'd0, idx_q};
            default:    rd_val = 32'd0;
        endcase
    end

    // Byte-strobed register writes on the accept edge; CTRL keeps only its low two bytes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q <= 32'd0;
            ctrl_q <= CTRL_RESET;
        end else if (accept) begin
            for (int b = 0; b < 4; b++) begin
                if (iomem_wstrb[b] && reg_sel == REG_DATA)
                    data_q[8*b +: 8] <= iomem_wdata[8*b +: 8];
                if (iomem_wstrb[b] && reg_sel == REG_CTRL && b < 2)
                    ctrl_q[8*b +: 8] <= iomem_wdata[8*b +: 8];
            end
        end
    end

    // One-cycle ready pulse; rdata captured on accept and held otherwise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'd0;
        end else begin
            iomem_ready <= accept;
            if (accept)
                iomem_rdata <= rd_val;
        end
    end

    // Slot prescaler and scan index; blank is high exactly while the prescaler sits at 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q <= '0;
            idx_q   <= 3'd0;
            blank_q <= 1'b1;
        end else begin
            presc_q <= presc_last ? '0 : presc_q + 1'b1;
            blank_q <= presc_last;
            if (presc_last)
                idx_q <= idx_q + 3'd1;
        end
    end

    // Registered display drive; masked or blanked slots stay dark but keep their full period
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            anodes <= ANODES_OFF;
            seg    <= SEG_OFF;
            dp     <= 1'b1;
        end else if (digit_on) begin
            anodes <= ~(8'd1 << idx_q);
            seg    <= cur_glyph;
            dp     <= ~dp_mask[idx_q];
        end else begin
            anodes <= ANODES_OFF;
            seg    <= SEG_OFF;
            dp     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_iomem_sevenseg_ctrl.sv
// Purpose: self-checking bench for iomem_sevenseg_ctrl against a cycle-count based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_iomem_sevenseg_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'd0;
    logic [31:0] iomem_addr = 32'd0;
    logic [31:0] iomem_wdata = 32'd0;
    logic [31:0] iomem_rdata;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  anodes;

    always #5 clk = ~clk;

    iomem_sevenseg_ctrl #(
        .ADDR_BASE   (8'h04),
        .REFRESH_DIV (DIV),
        .DIV_W       (3)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .seg         (seg),
        .dp          (dp),
        .anodes      (anodes)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Scan position is derived from the number of cycles since reset:
    // slot = (cycles / DIV) % 8, position within slot = cycles % DIV, and the
    // display shows the previous cycle's slot unless that cycle was position 0.
    logic [6:0]  hex_tab [16];
    int          m_cnt;
    int          m_slot;
    int          m_pos;
    logic        m_acc;
    logic [31:0] m_data;
    logic [15:0] m_ctrl;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_cnt   = 0;
            m_data  = 32'd0;
            m_ctrl  = 16'h00FF;
            m_ready = 1'b0;
            m_rdata = 32'd0;
            e_an    = 8'hFF;
            e_seg   = 7'h7F;
            e_dp    = 1'b1;
        end else begin
            m_slot = (m_cnt / DIV) % 8;
            m_pos  = m_cnt % DIV;
            if (m_pos != 0 && m_ctrl[m_slot]) begin
                e_an         = 8'hFF;
                e_an[m_slot] = 1'b0;
                e_seg        = hex_tab[m_data[m_slot*4 +: 4]];
                e_dp         = !m_ctrl[8 + m_slot];
            end else begin
                e_an  = 8'hFF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end
            m_acc = iomem_valid && !m_ready && (iomem_addr[31:24] == 8'h04);
            if (m_acc) begin
                case (iomem_addr[3:2])
                    2'd0:    m_rdata = m_data;
                    2'd1:    m_rdata = {16'd0, m_ctrl};
                    2'd2:    m_rdata = 32'(m_slot);
                    default: m_rdata = 32'd0;
                endcase
                for (int b = 0; b < 4; b++) begin
                    if (iomem_wstrb[b] && iomem_addr[3:2] == 2'd0)
                        m_data[8*b +: 8] = iomem_wdata[8*b +: 8];
                    if (iomem_wstrb[b] && iomem_addr[3:2] == 2'd1 && b < 2)
                        m_ctrl[8*b +: 8] = iomem_wdata[8*b +: 8];
                end
            end
            m_ready = m_acc;
            m_cnt++;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (resetn) begin
            chk("anodes", {24'd0, anodes}, {24'd0, e_an});
            chk("seg", {25'd0, seg}, {25'd0, e_seg});
            chk("dp", {31'd0, dp}, {31'd0, e_dp});
            chk("ready", {31'd0, iomem_ready}, {31'd0, m_ready});
            chk("rdata", iomem_rdata, m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd, output int lat);
        int n;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!iomem_ready && n < 20);
        if (!iomem_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL bus_timeout: no ready for addr %h after %0d cycles", a, n);
        end
        rd  = iomem_rdata;
        lat = n;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
    endtask

    logic [31:0] rd;
    int          lat;
    int          lowcnt [8];
    logic [6:0]  seen [8];
    logic [6:0]  dig_exp [8];
    int          offcnt, cnt_fe, cnt_fb, bad, dpbad, n;

    initial begin
        dig_exp = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};

        // 1. reset state, then first lit digit after the blank cycle
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_anodes", {24'd0, anodes}, 32'h0000_00FF);
        chk("rst_seg", {25'd0, seg}, 32'h0000_007F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_ready", {31'd0, iomem_ready}, 32'd0);
        chk("rst_rdata", iomem_rdata, 32'd0);
        repeat (2) @(negedge clk);
        chk("first_anodes", {24'd0, anodes}, 32'h0000_00FE);
        chk("first_seg", {25'd0, seg}, 32'h0000_0040);
        bus(32'h0400_0000, 4'h0, 32'd0, rd, lat);
        chk("rd_data_rst", rd, 32'd0);
        bus(32'h0400_0004, 4'h0, 32'd0, rd, lat);
        chk("rd_ctrl_rst", rd, 32'h0000_00FF);

        // 2. full-word DATA write and one scan period of observation
        bus(32'h0400_0000, 4'hF, 32'h8765_4321, rd, lat);
        chk("ready_latency", 32'(lat), 32'd1);
        @(negedge clk);
        offcnt = 0;
        for (int i = 0; i < 8; i++) begin
            lowcnt[i] = 0;
            seen[i]   = 7'h7F;
        end
        for (int c = 0; c < 32; c++) begin
            if (anodes == 8'hFF) offcnt++;
            for (int i = 0; i < 8; i++) begin
                if (anodes == ~(8'd1 << i)) begin
                    lowcnt[i]++;
                    seen[i] = seg;
                end
            end
            @(negedge clk);
        end
        chk("off_cycles", 32'(offcnt), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("low_cycles_d%0d", i), 32'(lowcnt[i]), 32'd3);
            chk($sformatf("glyph_d%0d", i), {25'd0, seen[i]}, {25'd0, dig_exp[i]});
        end

        // 3. sparse enable mask with a decimal point on digit 0
        bus(32'h0400_0004, 4'hF, 32'h0000_0105, rd, lat);
        @(negedge clk);
        cnt_fe = 0; cnt_fb = 0; bad = 0; dpbad = 0;
        for (int c = 0; c < 32; c++) begin
            if (anodes == 8'hFE) cnt_fe++;
            else if (anodes == 8'hFB) cnt_fb++;
            else if (anodes != 8'hFF || seg != 7'h7F) bad++;
            if (dp != (anodes != 8'hFE)) dpbad++;
            @(negedge clk);
        end
        chk("mask_fe_cycles", 32'(cnt_fe), 32'd3);
        chk("mask_fb_cycles", 32'(cnt_fb), 32'd3);
        chk("mask_other_lit", 32'(bad), 32'd0);
        chk("mask_dp", 32'(dpbad), 32'd0);

        // 4. single-byte write into DATA
        bus(32'h0400_0000, 4'b0010, 32'h0000_AB00, rd, lat);
        bus(32'h0400_0000, 4'h0, 32'd0, rd, lat);
        chk("byte_write", rd, 32'h8765_AB21);
        n = 0;
        while (anodes != 8'hFB && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("digit2_glyph", {25'd0, seg}, 32'h0000_0003);

        // 5. foreign address, reserved offset, STATUS reads
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'hFFFF_FFFF;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (iomem_ready) n++;
        end
        chk("foreign_no_ready", 32'(n), 32'd0);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        bus(32'h0400_000C, 4'h0, 32'd0, rd, lat);
        chk("reserved_read", rd, 32'd0);
        bus(32'h0400_000C, 4'hF, 32'h1234_5678, rd, lat);
        bus(32'h0400_0000, 4'h0, 32'd0, rd, lat);
        chk("reserved_wr_ignored", rd, 32'h8765_AB21);
        for (int k = 0; k < 24; k++)
            bus(32'h0400_0008, 4'h0, 32'd0, rd, lat);

        // 6a. reset while a request is presented but not yet accepted
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0000;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'hFFFF_FFFF;
        #2 resetn = 1'b0;
        #1;
        chk("arst_anodes", {24'd0, anodes}, 32'h0000_00FF);
        chk("arst_seg", {25'd0, seg}, 32'h0000_007F);
        chk("arst_dp", {31'd0, dp}, 32'd1);
        @(posedge clk);
        #1;
        chk("arst_ready", {31'd0, iomem_ready}, 32'd0);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        @(negedge clk);
        resetn = 1'b1;
        bus(32'h0400_0000, 4'h0, 32'd0, rd, lat);
        chk("arst_data", rd, 32'd0);

        // 6b. reset while ready is high
        bus(32'h0400_0000, 4'hF, 32'hCAFE_F00D, rd, lat);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0000;
        iomem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        chk("ready_before_rst", {31'd0, iomem_ready}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("rst_during_ready", {31'd0, iomem_ready}, 32'd0);
        chk("rst_rdata_clear", iomem_rdata, 32'd0);
        iomem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // 7. randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            iomem_valid = 1'($urandom_range(0, 1));
            iomem_addr  = {($urandom_range(0, 3) != 0) ? 8'h04 : 8'($urandom),
                           20'($urandom), 2'($urandom), 2'($urandom)};
            iomem_wstrb = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            iomem_wdata = $urandom;
        end
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
